// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: alignment check, req/gnt + rvalid bus, big-endian load formatting.
// Optional abort of a stuck bus access after TIMEOUT cycles when LSU_TIMEOUT_EN is defined.
module mem_access_ctrl #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_sel,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_rt_old,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t      state_q, state_d;
   logic [2:0]  sel_q, sel_d;
   logic [1:0]  alo_q, alo_d;
   logic [31:0] rt_q, rt_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        rsp_err_q, rsp_err_d;
   logic        expire;
   logic        req_bad;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;

   function automatic logic [31:0] fmt_load(input logic [2:0] sel, input logic [1:0] a,
                                            input logic [31:0] rd, input logic [31:0] rt);
      logic [4:0]  sh_l;
      logic [4:0]  sh_r;
      logic [31:0] t;
      logic [15:0] h;
      logic [31:0] res;
      sh_l = {a, 3'b000};
      sh_r = {2'd3 - a, 3'b000};
      t    = rd >> sh_r;
      h    = a[1] ? rd[15:0] : rd[31:16];
      case (sel)
         3'd0:    res = {{24{t[7]}}, t[7:0]};
         3'd1:    res = {24'h0, t[7:0]};
         3'd2:    res = {{16{h[15]}}, h};
         3'd3:    res = {16'h0, h};
         3'd4:    res = rd;
         3'd5:    res = (rd << sh_l) | (rt & ((32'h1 << sh_l) - 32'h1));
         3'd6:    res = t | (rt & ~(32'hFFFF_FFFF >> sh_r));
         default: res = 32'h0;
      endcase
      return res;
   endfunction

   // Request decode: legality, alignment and store lane placement.
   always_comb begin
      req_bad  = 1'b0;
      st_be    = 4'b1111;
      st_wdata = req_wdata;
      if (req_we) begin
         req_bad = !(req_sel == 3'd0 || req_sel == 3'd2 || req_sel == 3'd4);
      end else begin
         req_bad = (req_sel == 3'd7);
      end
      if ((req_sel == 3'd2 || req_sel == 3'd3) && req_addr[0]) begin
         req_bad = 1'b1;
      end
      if (req_sel == 3'd4 && req_addr[1:0] != 2'b00) begin
         req_bad = 1'b1;
      end
      if (req_we && req_sel == 3'd0) begin
         st_be    = 4'b1000 >> req_addr[1:0];
         st_wdata = {4{req_wdata[7:0]}};
      end else if (req_we && req_sel == 3'd2) begin
         st_be    = req_addr[1] ? 4'b0011 : 4'b1100;
         st_wdata = {2{req_wdata[15:0]}};
      end
   end

`ifdef LSU_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CW-1:0] cnt_q;

   // Held at zero in IDLE, so it is clear on every entry to REQ.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (state_q == S_REQ || state_q == S_WAIT) begin
         cnt_q <= cnt_q + 1'b1;
      end else begin
         cnt_q <= '0;
      end
   end

   assign expire = (cnt_q == CW'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
   assign expire         = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      alo_d       = alo_q;
      rt_d        = rt_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               sel_d      = req_sel;
               alo_d      = req_addr[1:0];
               rt_d       = req_rt_old;
               rsp_data_d = 32'h0;
               rsp_err_d  = req_bad;
               if (req_bad) begin
                  state_d = S_RESP;
               end else begin
                  mem_we_d    = req_we;
                  mem_addr_d  = {req_addr[31:2], 2'b00};
                  mem_be_d    = st_be;
                  mem_wdata_d = st_wdata;
                  state_d     = S_REQ;
               end
            end
         end
         S_REQ: begin
            // A grant in the expiry cycle still wins.
            if (mem_gnt) begin
               state_d = mem_we_q ? S_RESP : S_WAIT;
            end else if (expire) begin
               rsp_err_d = 1'b1;
               state_d   = S_RESP;
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               rsp_data_d = fmt_load(sel_q, alo_q, mem_rdata, rt_q);
               state_d    = S_RESP;
            end else if (expire) begin
               rsp_err_d = 1'b1;
               state_d   = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sel_q       <= 3'd0;
         alo_q       <= 2'd0;
         rt_q        <= 32'h0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_be_q    <= 4'h0;
         mem_wdata_q <= 32'h0;
         rsp_data_q  <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         alo_q       <= alo_d;
         rt_q        <= rt_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign mem_req   = (state_q == S_REQ);
   assign rsp_valid = (state_q == S_RESP);
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

endmodule
